// File: rtl/activation_ctrl_if.sv
// Shared types and the command/stream interface between the activation sequencer
// and its surroundings (tile controller, requantizer stream, activation datapath).
package activation_ctrl_pkg;
    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_GELU     = 2'd2
    } activation_e;

    typedef enum logic {
        REQUANT_PER_LAYER   = 1'b0,
        REQUANT_PER_CHANNEL = 1'b1
    } requant_mode_e;

    typedef logic signed [7:0]  gelu_const_t;
    typedef logic [15:0]        requant_const_t;
    typedef logic signed [31:0] requant_t;
endpackage

interface activation_ctrl_if #(
    parameter int unsigned LEN_W = 16
);
    import activation_ctrl_pkg::*;

    logic           start_i;
    activation_e    activation_i;
    requant_mode_e  requant_mode_i;
    gelu_const_t    one_i;
    gelu_const_t    b_i;
    gelu_const_t    c_i;
    requant_const_t requant_mult_i;
    requant_const_t requant_shift_i;
    requant_t       requant_add_i;
    logic [LEN_W-1:0] len_i;

    logic           in_valid_i;
    logic           in_ready_o;

    activation_e    act_activation_o;
    requant_mode_e  act_requant_mode_o;
    gelu_const_t    act_one_o;
    gelu_const_t    act_b_o;
    gelu_const_t    act_c_o;
    requant_const_t act_requant_mult_o;
    requant_const_t act_requant_shift_o;
    requant_t       act_requant_add_o;

    logic           calc_en_o;
    logic           out_valid_o;
    logic           out_ready_i;
    logic           busy_o;
    logic           done_o;
    logic           cfg_err_o;

    modport master (
        output start_i, activation_i, requant_mode_i, one_i, b_i, c_i,
               requant_mult_i, requant_shift_i, requant_add_i, len_i,
               in_valid_i, out_ready_i,
        input  in_ready_o, act_activation_o, act_requant_mode_o, act_one_o,
               act_b_o, act_c_o, act_requant_mult_o, act_requant_shift_o,
               act_requant_add_o, calc_en_o, out_valid_o, busy_o, done_o,
               cfg_err_o
    );

    modport slave (
        input  start_i, activation_i, requant_mode_i, one_i, b_i, c_i,
               requant_mult_i, requant_shift_i, requant_add_i, len_i,
               in_valid_i, out_ready_i,
        output in_ready_o, act_activation_o, act_requant_mode_o, act_one_o,
               act_b_o, act_c_o, act_requant_mult_o, act_requant_shift_o,
               act_requant_add_o, calc_en_o, out_valid_o, busy_o, done_o,
               cfg_err_o
    );
endinterface

// File: rtl/activation_ctrl.sv
// Tile sequencer for the activation datapath: shadows the tile configuration,
// counts vectors, tracks in-flight valids and freezes the pipe on backpressure.
module activation_ctrl
    import activation_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LEN_W   = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    activation_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LEN_W-1:0] in_cnt_q, out_cnt_q, len_q;

    activation_e      act_q;
    requant_mode_e    mode_q;
    gelu_const_t      one_q, b_q, c_q;
    requant_const_t   mult_q, shift_q;
    requant_t         add_q;

    logic start_ok;
    logic out_valid;
    logic calc_en;
    logic in_ready;
    logic in_acc;
    logic out_hs;

    always_comb begin
        start_ok  = bus.start_i && (state_q == IDLE);
        out_valid = vld_q[LATENCY-1];
        calc_en   = !out_valid || bus.out_ready_i;
        in_ready  = (state_q == RUN) && calc_en;
        in_acc    = bus.in_valid_i && in_ready;
        out_hs    = out_valid && bus.out_ready_i;

        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ok) state_d = (bus.len_i == '0) ? DONE : RUN;
            RUN:   if (in_acc && (in_cnt_q == len_q - LEN_W'(1))) state_d = DRAIN;
            DRAIN: if (out_hs && (out_cnt_q == len_q - LEN_W'(1))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bit 0 is the pipe head; the whole register freezes with the datapath.
        vld_d = vld_q;
        if (calc_en) begin
            vld_d[0] = in_acc;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            vld_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            len_q     <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            if (start_ok) begin
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
                len_q     <= bus.len_i;
            end else begin
                if (in_acc) in_cnt_q  <= in_cnt_q + LEN_W'(1);
                if (out_hs) out_cnt_q <= out_cnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q   <= ACT_IDENTITY;
            mode_q  <= REQUANT_PER_LAYER;
            one_q   <= '0;
            b_q     <= '0;
            c_q     <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            add_q   <= '0;
        end else if (start_ok) begin
            act_q   <= bus.activation_i;
            mode_q  <= bus.requant_mode_i;
            one_q   <= bus.one_i;
            b_q     <= bus.b_i;
            c_q     <= bus.c_i;
            mult_q  <= bus.requant_mult_i;
            shift_q <= bus.requant_shift_i;
            add_q   <= bus.requant_add_i;
        end
    end

    assign bus.in_ready_o          = in_ready;
    assign bus.calc_en_o           = calc_en;
    assign bus.out_valid_o         = out_valid;
    assign bus.busy_o              = (state_q != IDLE);
    assign bus.done_o              = (state_q == DONE);
    assign bus.cfg_err_o           = bus.start_i && (state_q != IDLE);
    assign bus.act_activation_o    = act_q;
    assign bus.act_requant_mode_o  = mode_q;
    assign bus.act_one_o           = one_q;
    assign bus.act_b_o             = b_q;
    assign bus.act_c_o             = c_q;
    assign bus.act_requant_mult_o  = mult_q;
    assign bus.act_requant_shift_o = shift_q;
    assign bus.act_requant_add_o   = add_q;

endmodule

// File: tb/tb_activation_ctrl.sv
// Scoreboard bench for activation_ctrl: randomized tiles through a stand-in
// datapath pipe driven by calc_en_o, outputs checked in order against a queue.
module tb_activation_ctrl;
    import activation_ctrl_pkg::*;

    localparam int unsigned LAT = 4;
    localparam int unsigned LW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activation_ctrl_if #(.LEN_W(LW)) bus();

    activation_ctrl #(.LATENCY(LAT), .LEN_W(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Stand-in datapath: fixed-depth pipe advanced only by calc_en_o.
    logic [15:0] in_data;
    logic [15:0] pipe [LAT];
    logic [15:0] out_data;
    assign out_data = pipe[LAT-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (bus.calc_en_o) begin
            pipe[0] <= in_data;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    typedef struct packed {
        logic [15:0] data;
        activation_e act;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   hs_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks stall behaviour.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(bus.out_valid_o), 32'd1);
                check("stall_data_hold", 32'(out_data), 32'(prev_data));
            end
            if (bus.out_valid_o && !bus.out_ready_i) begin
                check("stall_calc_en", 32'(bus.calc_en_o), 32'd0);
                check("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
                prev_stall = 1'b1;
                prev_data  = out_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got data %0h expected no output", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_act", 32'(bus.act_activation_o), 32'(mon_e.act));
                end
            end
            if (bus.done_o) check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        end
    end

    task automatic set_idle_inputs();
        bus.start_i         = 1'b0;
        bus.activation_i    = ACT_IDENTITY;
        bus.requant_mode_i  = REQUANT_PER_LAYER;
        bus.one_i           = '0;
        bus.b_i             = '0;
        bus.c_i             = '0;
        bus.requant_mult_i  = '0;
        bus.requant_shift_i = '0;
        bus.requant_add_i   = '0;
        bus.len_i           = '0;
        bus.in_valid_i      = 1'b0;
        bus.out_ready_i     = 1'b1;
        in_data             = '0;
    endtask

    // vmode: 0 always valid, 1 alternate cycles, 2 random; rmode: 0 always ready,
    // 1 pattern 1,0,0,1, 2 random; err_cycle: cycle with an illegal mid-tile start.
    task automatic run_tile(input activation_e act, input int len, input int vmode,
                            input int rmode, input int err_cycle, input bit timing);
        logic [15:0]    items[$];
        requant_const_t mult, shift;
        requant_t       add;
        gelu_const_t    one;
        int idx = 0, hs0, errs = 0;
        int first_acc = -1, last_acc = -1, first_ov = -1, last_ov = -1;
        int done_c = -1, idle_c = -1;
        bit ir_seen = 1'b0;
        bit ov_seen = 1'b0;

        for (int i = 0; i < len; i++) begin
            items.push_back(16'($urandom));
            exp_q.push_back('{data: items[i], act: act});
        end
        hs0   = hs_total;
        mult  = requant_const_t'($urandom);
        shift = requant_const_t'($urandom_range(0, 31));
        add   = requant_t'($urandom);
        one   = gelu_const_t'($urandom);

        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.activation_i    = act;
        bus.requant_mode_i  = requant_mode_e'($urandom_range(0, 1));
        bus.one_i           = one;
        bus.requant_mult_i  = mult;
        bus.requant_shift_i = shift;
        bus.requant_add_i   = add;
        bus.len_i           = LW'(len);
        bus.in_valid_i      = 1'b0;
        bus.out_ready_i     = 1'b1;

        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            bus.start_i = (c == err_cycle);
            if (c == err_cycle) begin
                bus.activation_i   = ACT_RELU;
                bus.requant_mult_i = ~mult;
            end
            case (rmode)
                0:       bus.out_ready_i = 1'b1;
                1:       bus.out_ready_i = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
                default: bus.out_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (idx < len) begin
                case (vmode)
                    0:       bus.in_valid_i = 1'b1;
                    1:       bus.in_valid_i = (c % 2 == 1);
                    default: bus.in_valid_i = 1'($urandom_range(0, 1));
                endcase
            end else begin
                bus.in_valid_i = 1'b0;
            end
            in_data = bus.in_valid_i ? items[idx] : 16'($urandom);
            #1;
            if (c == err_cycle) check("cfg_err_pulse", 32'(bus.cfg_err_o), 32'd1);
            if (bus.cfg_err_o) errs++;
            if (len == 0 && c == 1) check("zero_len_busy", 32'(bus.busy_o), 32'd1);
            if (done_c < 0) check("shadow_act_stable", 32'(bus.act_activation_o), 32'(act));
            if (bus.in_valid_i && bus.in_ready_o) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                idx++;
            end
            if (bus.in_ready_o) ir_seen = 1'b1;
            if (bus.out_valid_o) begin
                ov_seen = 1'b1;
                if (first_ov < 0) first_ov = c;
                last_ov = c;
            end
            if (bus.done_o) begin
                if (done_c >= 0) check("done_single_pulse", 32'(c), 32'(done_c));
                else done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                idle_c = bus.busy_o ? -1 : c;
                break;
            end
        end
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b0;

        check("tile_done_seen", 32'(done_c >= 0), 32'd1);
        check("busy_low_after_done", 32'(idle_c), 32'(done_c + 1));
        check("accept_count", 32'(idx), 32'(len));
        check("handshake_count", 32'(hs_total - hs0), 32'(len));
        check("cfg_err_count", 32'(errs), 32'(err_cycle > 0));
        check("shadow_mult", 32'(bus.act_requant_mult_o), 32'(mult));
        check("shadow_shift", 32'(bus.act_requant_shift_o), 32'(shift));
        check("shadow_add", 32'(bus.act_requant_add_o), 32'(add));
        check("shadow_one", 32'(bus.act_one_o), 32'(one));
        if (timing) begin
            check("first_accept_cycle", 32'(first_acc), 32'(1));
            check("last_accept_cycle", 32'(last_acc), 32'(len));
            check("first_valid_cycle", 32'(first_ov), 32'(1 + LAT));
            check("last_valid_cycle", 32'(last_ov), 32'(len + LAT));
            check("done_cycle", 32'(done_c), 32'(len + LAT + 1));
        end
        if (len == 0) begin
            check("zero_len_done_cycle", 32'(done_c), 32'd1);
            check("zero_len_no_ready", 32'(ir_seen), 32'd0);
            check("zero_len_no_valid", 32'(ov_seen), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_done"}, 32'(bus.done_o), 32'd0);
        check({tag, "_calc_en"}, 32'(bus.calc_en_o), 32'd1);
        check({tag, "_act"}, 32'(bus.act_activation_o), 32'(ACT_IDENTITY));
        check({tag, "_mult"}, 32'(bus.act_requant_mult_o), 32'd0);
        check({tag, "_add"}, 32'(bus.act_requant_add_o), 32'd0);
    endtask

    initial begin
        logic [15:0] ritems[$];

        set_idle_inputs();
        #1;
        check_reset_values("reset");
        check("reset_cfg_err", 32'(bus.cfg_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_tile(ACT_GELU, 8, 0, 0, 0, 1'b1);
        run_tile(ACT_RELU, 16, 0, 1, 0, 1'b0);
        run_tile(ACT_IDENTITY, 4, 1, 0, 0, 1'b0);
        run_tile(ACT_GELU, 6, 0, 2, 3, 1'b0);
        run_tile(ACT_RELU, 5, 2, 2, 0, 1'b0);
        run_tile(ACT_GELU, 0, 0, 0, 0, 1'b0);
        repeat (6) begin
            run_tile(activation_e'($urandom_range(0, 2)), int'($urandom_range(1, 20)), 2, 2, 0, 1'b0);
        end

        // Mid-tile reset with three vectors in flight.
        for (int i = 0; i < 10; i++) begin
            ritems.push_back(16'($urandom));
            exp_q.push_back('{data: ritems[i], act: ACT_GELU});
        end
        @(negedge clk);
        bus.start_i        = 1'b1;
        bus.activation_i   = ACT_GELU;
        bus.requant_mult_i = 16'h1234;
        bus.len_i          = LW'(10);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start_i    = 1'b0;
            bus.in_valid_i = 1'b1;
            in_data        = ritems[c-1];
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
        check("pre_reset_act", 32'(bus.act_activation_o), 32'(ACT_GELU));
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            check("done_during_reset", 32'(bus.done_o), 32'd0);
            check("valid_during_reset", 32'(bus.out_valid_o), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_reset_valid", 32'(bus.out_valid_o), 32'd0);
        run_tile(ACT_IDENTITY, 2, 0, 0, 0, 1'b1);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/activation_ctrl.md
# activation_ctrl

Sequencer for the activation datapath (Identity/ReLU/GELU with requantization). It accepts a per-tile configuration command, holds that configuration in shadow registers that drive the datapath for the whole tile, and counts input vectors. It tracks in-flight vectors through the fixed-latency activation pipeline and applies output backpressure by freezing the pipeline through its calc-enable. It sits between the requantizer output stream and the activation unit, and signals tile completion to the top-level controller.

## Interface
- LATENCY, 4: pipeline depth of the activation datapath, in enabled cycles; at least 1.
- LEN_W, 16: width of the tile length counter.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse that requests a new tile.
- activation_i  in  activation_e  Identity/Relu/Gelu for the tile.
- requant_mode_i  in  requant_mode_e  requant mode for the tile.
- one_i, b_i, c_i  in  gelu_const_t  GELU constants.
- requant_mult_i, requant_shift_i  in  requant_const_t  activation requant multiplier and shift.
- requant_add_i  in  requant_t  activation requant offset.
- len_i  in  LEN_W  number of N_PE-wide vectors in the tile.
- in_valid_i  in  1  upstream vector valid.
- in_ready_o  out  1  vector accepted when in_valid_i && in_ready_o.
- act_*_o  out  same as the matching inputs  shadowed configuration driven to the datapath (activation, requant_mode, one, b, c, requant_mult, requant_shift, requant_add).
- calc_en_o  out  1  datapath stage enable.
- out_valid_o  out  1  datapath output valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse after the last output handshake.
- cfg_err_o  out  1  one-cycle pulse when start_i is ignored.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start_i captures all configuration inputs and len_i into the shadow registers.
  - Clears the input and output counters and goes to RUN.
  - If len_i==0, goes to DONE instead.
- RUN:
  - in_ready_o = calc_en_o.
  - Each accepted vector increments in_cnt and inserts a 1 at the head of the valid shift register (vld_sr, LATENCY bits); a non-accepting enabled cycle inserts a 0.
  - When in_cnt reaches len, go to DRAIN.
- DRAIN:
  - in_ready_o = 0; the pipeline continues to advance, inserting 0s.
  - When out_cnt reaches len, go to DONE.
- DONE: asserts done_o for one cycle, then goes to IDLE.
- calc_en_o = !out_valid_o || out_ready_i.
  - A stalled output freezes the whole datapath and vld_sr.
  - calc_en_o is also high in IDLE and DONE, where vld_sr is all-zero.
- out_valid_o = vld_sr[LATENCY-1].
  - out_cnt increments on out_valid_o && out_ready_i.
- Shadow registers change only on an accepted start, so the datapath configuration is stable for every vector of a tile.
- start_i outside IDLE is ignored: cfg_err_o pulses and the shadows are unchanged.
- busy_o = state != IDLE.
- Counters are LEN_W bits. len_i is at most 2^LEN_W-1, so the counters never wrap within a tile.

## Timing
- Reset values:
  - state IDLE.
  - in_ready_o 0, out_valid_o 0, busy_o 0, done_o 0, cfg_err_o 0, calc_en_o 1.
  - vld_sr 0, counters 0.
  - Shadows: activation Identity, all others 0.
- Reset asserted mid-tile clears everything immediately, with no done_o. In-flight datapath data is discarded by forcing vld_sr to 0.
- start accepted at edge t:
  - busy_o and in_ready_o are high from t+1.
  - The first vector is accepted at t+1 at the earliest.
- A vector accepted at enabled edge k appears with out_valid_o high after LATENCY enabled edges. With no stalls, a vector accepted at cycle k is valid in cycle k+LATENCY.
- Throughput is one vector per cycle when out_ready_i is held high.
- With out_ready_i low and out_valid_o high:
  - calc_en_o=0 and in_ready_o=0.
  - The output data and valid hold stable until the handshake.
- done_o fires the cycle after the final output handshake; the next start is accepted the cycle after done_o.
- len_i=0: done_o is high at t+1 and busy_o is high only at t+1.
- start_i in the same cycle as done_o is ignored and flagged with cfg_err_o.

## Test plan
- **Basic Gelu tile:** start with Gelu, len=8, in_valid_i=1 and out_ready_i=1 constant.
  - 8 accepts in cycles 1-8 and out_valid_o in cycles 5-12 for LATENCY=4.
  - done_o in cycle 13 and busy_o low in cycle 14.
  - Outputs match the golden gelu vectors.
- **Backpressure:** Relu, len=16, out_ready_i toggling 1,0,0,1 repeatedly.
  - Each stall holds out_valid_o and the data, and drives calc_en_o and in_ready_o low.
  - Exactly 16 output handshakes in order; no vector lost or duplicated.
- **Bubbles:** Identity, len=4, in_valid_i high on alternate cycles.
  - out_valid_o follows with matching gaps and output equals input.
  - out_cnt reaches 4 before done_o.
- **Config stability:** pulse start_i during RUN with activation changed to Relu.
  - cfg_err_o pulses once.
  - act_activation_o stays Gelu until done_o.
  - The next start in IDLE updates it.
- **Zero length:** start with len=0.
  - done_o at cycle 1, in_ready_o never high, no out_valid_o.
- **Reset mid-tile:** assert rst_i with 3 vectors in flight.
  - All outputs take their reset values asynchronously and no done_o is produced.
  - After release, a new len=2 tile completes normally.
